// File: rtl/aes_gcm_pkg.sv
// aes_gcm_pkg: shared widths, FIFO entry layout, FSM states and length helpers for the output packer.
package aes_gcm_pkg;
  localparam int CT_W   = 128;
  localparam int BYP_W  = 289;
  localparam int KEEP_W = 16;
  localparam int LEN_W  = 16;
  localparam int WC_W   = 13;
  localparam int ENT_W  = CT_W + BYP_W + 2 + KEEP_W;
  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;
  typedef struct packed {
    logic [CT_W-1:0]   data;
    logic [BYP_W-1:0]  bypass;
    logic              first;
    logic              last;
    logic [KEEP_W-1:0] keep;
  } entry_t;
  // a zero-length packet still occupies one word
  function automatic logic [WC_W-1:0] words(input logic [LEN_W-1:0] len);
    return len == '0 ? WC_W'(1) : WC_W'((17'(len) + 17'd15) >> 4);
  endfunction
  function automatic logic [KEEP_W-1:0] last_keep(input logic [3:0] r);
    return r == 4'd0 ? '1 : ~({KEEP_W{1'b1}} >> r);
  endfunction
endpackage

// File: rtl/aes_out_packer_if.sv
// aes_out_packer_if: downstream word stream with ready/valid handshake and packet framing.
interface aes_out_packer_if;
  import aes_gcm_pkg::*;
  logic              o_valid;
  logic              i_ready;
  logic [CT_W-1:0]   o_data;
  logic [BYP_W-1:0]  o_bypass;
  logic              o_first;
  logic              o_last;
  logic [KEEP_W-1:0] o_keep;
  modport master (output o_valid, o_data, o_bypass, o_first, o_last, o_keep, input i_ready);
  modport slave  (input o_valid, o_data, o_bypass, o_first, o_last, o_keep, output i_ready);
endinterface

// File: rtl/aes_out_fifo.sv
// aes_out_fifo: first-word-fall-through FIFO exposing its occupancy; output reads zero when empty.
module aes_out_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   occ
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd;
  assign rd       = rd_en && rd_valid;
  assign rd_valid = cnt_q != '0;
  assign rd_data  = rd_valid ? mem_q[rp_q] : '0;
  assign occ      = cnt_q;
  always_comb begin
    wp_d  = wr_en ? wp_q + 1'b1 : wp_q;
    rp_d  = rd ? rp_q + 1'b1 : rp_q;
    cnt_d = cnt_q + CW'(wr_en) - CW'(rd);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (wr_en) mem_q[wp_q] <= wr_data;
  // the packer reserves space per packet, so this can only fire on a logic bug
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !(wr_en && cnt_q == CW'(DEPTH)));
endmodule

// File: rtl/aes_out_packer.sv
// aes_out_packer: frames GCM cipher words into packets, admitting whole packets only when the
// FIFO has room for all of their words and dropping them otherwise.
module aes_out_packer import aes_gcm_pkg::*; #(
  parameter int DEPTH   = 128,
  parameter int LEN_LSB = 33
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_cp_ready,
  input  logic [CT_W-1:0]   i_cipher_text,
  input  logic [BYP_W-1:0]  i_bypass_text,
  aes_out_packer_if.master  dn,
  output logic              o_drop,
  output logic [31:0]       o_pkt_count,
  output logic [15:0]       o_drop_count
);
  localparam int AW = $clog2(DEPTH);
  state_t            state_q, state_d;
  logic [WC_W-1:0]   rem_q, rem_d;
  logic [KEEP_W-1:0] lkeep_q, lkeep_d;
  logic              drop_q, drop_d;
  logic [31:0]       pkt_q, pkt_d;
  logic [15:0]       dcnt_q, dcnt_d;
  logic [LEN_W-1:0]  len;
  logic [WC_W-1:0]   w;
  logic [AW:0]       occ;
  logic              fits, wr, rd_valid;
  entry_t            wr_ent, rd_ent;
  assign len  = i_bypass_text[LEN_LSB +: LEN_W];
  assign w    = words(len);
  assign fits = 17'(w) <= 17'(DEPTH) - 17'(occ);
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    lkeep_d = lkeep_q;
    drop_d  = 1'b0;
    wr      = 1'b0;
    wr_ent  = '{data: i_cipher_text, bypass: i_bypass_text, first: 1'b0, last: 1'b0, keep: '1};
    if (i_cp_ready)
      case (state_q)
        IDLE: begin
          lkeep_d = last_keep(len[3:0]);
          rem_d   = w - WC_W'(1);
          wr      = fits;
          drop_d  = !fits;
          wr_ent.first = 1'b1;
          wr_ent.last  = w == WC_W'(1);
          wr_ent.keep  = w == WC_W'(1) ? last_keep(len[3:0]) : '1;
          state_d = w == WC_W'(1) ? IDLE : fits ? PASS : DROP;
        end
        PASS: begin
          wr          = 1'b1;
          wr_ent.last = rem_q == WC_W'(1);
          wr_ent.keep = rem_q == WC_W'(1) ? lkeep_q : '1;
          rem_d       = rem_q - WC_W'(1);
          state_d     = rem_q == WC_W'(1) ? IDLE : PASS;
        end
        DROP: begin
          rem_d   = rem_q - WC_W'(1);
          state_d = rem_q == WC_W'(1) ? IDLE : DROP;
        end
        default: state_d = IDLE;
      endcase
    pkt_d  = pkt_q + 32'(wr && wr_ent.last);
    dcnt_d = dcnt_q + 16'(drop_d);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      lkeep_q <= '1;
      drop_q  <= 1'b0;
      pkt_q   <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      lkeep_q <= lkeep_d;
      drop_q  <= drop_d;
      pkt_q   <= pkt_d;
      dcnt_q  <= dcnt_d;
    end
  aes_out_fifo #(.W(ENT_W), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr),
    .wr_data  (wr_ent),
    .rd_en    (dn.i_ready),
    .rd_data  (rd_ent),
    .rd_valid (rd_valid),
    .occ      (occ)
  );
  assign dn.o_valid   = rd_valid;
  assign dn.o_data    = rd_ent.data;
  assign dn.o_bypass  = rd_ent.bypass;
  assign dn.o_first   = rd_ent.first;
  assign dn.o_last    = rd_ent.last;
  assign dn.o_keep    = rd_ent.keep;
  assign o_drop       = drop_q;
  assign o_pkt_count  = pkt_q;
  assign o_drop_count = dcnt_q;
endmodule
